pc_gen: RTL and testbench

//  Parametrised fetch-PC generator for the RV64 pipeline; replaces the fixed-width PC register.

---
 rtl/pc_gen_if.sv | 32 +++
 rtl/pc_gen.sv | 147 ++++++++++++++
 tb/tb_pc_gen.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// pc_gen_if: bundles the fetch-PC generator's redirect, stall and IF handshake
// signals. Member names keep the original pc_gen port names.
//   master : pc_gen side (consumes redirect/stall/ready, drives PC and flags)
//   slave  : pipeline side (drives redirect/stall/ready, observes PC and flags)
interface pc_gen_if #(
    parameter int unsigned XLEN = 64
);
    logic            trap_en_i;
    logic [XLEN-1:0] trap_addr_i;
    logic            jump_en_i;
    logic [XLEN-1:0] jump_addr_i;
    logic [XLEN-1:0] jump_src_pc_i;
    logic            stall_en_i;
    logic            if_ready_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            redirect_o;
    logic            pred_taken_o;
    logic [31:0]     stall_cnt_o;

    modport master (
        input  trap_en_i, trap_addr_i, jump_en_i, jump_addr_i, jump_src_pc_i,
        input  stall_en_i, if_ready_i,
        output pc_o, pc_valid_o, redirect_o, pred_taken_o, stall_cnt_o
    );

    modport slave (
        output trap_en_i, trap_addr_i, jump_en_i, jump_addr_i, jump_src_pc_i,
        output stall_en_i, if_ready_i,
        input  pc_o, pc_valid_o, redirect_o, pred_taken_o, stall_cnt_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: parametrised fetch-PC generator.
//   Trap redirect > jump redirect > hold (stall / IF not ready / boot) > advance.
//   Redirect targets are aligned to INC. Every output is registered.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active-low
//   bus  - pc_gen_if.master: redirect/stall/ready inputs, pc_o, pc_valid_o,
//          redirect_o, pred_taken_o, stall_cnt_o outputs
// Build option: define PC_GEN_BTB_EN to add a direct-mapped BTB that predicts
// the next PC on an advance; otherwise the advance is always pc+INC.
module pc_gen #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'('h8000_0000),
    parameter int unsigned     INC       = 4,
    parameter int unsigned     BTB_DEPTH = 8
) (
    input logic       clk,
    input logic       rst,
    pc_gen_if.master  bus
);
    if ((INC == 0) || ((INC & (INC - 1)) != 0)) begin : g_bad_inc
        $error("pc_gen: INC must be a power of 2");
    end
    if ((BTB_DEPTH < 2) || ((BTB_DEPTH & (BTB_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pc_gen: BTB_DEPTH must be a power of 2 and >= 2");
    end

    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(INC_X - XLEN'(1));

    typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            redir_q, redir_d;
    logic            pred_q, pred_d;
    logic [31:0]     cnt_q, cnt_d;
    logic            fire;
    logic            btb_hit;
    logic [XLEN-1:0] btb_tgt;

    assign fire = valid_q & bus.if_ready_i & ~bus.stall_en_i;

`ifdef PC_GEN_BTB_EN
    localparam int unsigned ALIGN = $clog2(INC);
    localparam int unsigned IDXW  = $clog2(BTB_DEPTH);
    localparam int unsigned TAGW  = XLEN - ALIGN - IDXW;

    logic [BTB_DEPTH-1:0] btb_vld_q;
    logic [TAGW-1:0]      btb_tag_q [BTB_DEPTH];
    logic [XLEN-1:0]      btb_tgt_q [BTB_DEPTH];
    logic [IDXW-1:0]      rd_idx, wr_idx;
    logic                 btb_we;

    assign rd_idx  = pc_q[ALIGN +: IDXW];
    assign wr_idx  = bus.jump_src_pc_i[ALIGN +: IDXW];
    assign btb_we  = bus.jump_en_i & ~bus.trap_en_i;
    // Registered storage: a same-cycle write to rd_idx is seen next cycle,
    // so the lookup always uses the old entry.
    assign btb_hit = btb_vld_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[XLEN-1 -: TAGW]);
    assign btb_tgt = btb_tgt_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_vld_q <= '0;
        end else if (btb_we) begin
            btb_vld_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_q[wr_idx] <= bus.jump_src_pc_i[XLEN-1 -: TAGW];
            btb_tgt_q[wr_idx] <= bus.jump_addr_i & ALIGN_MASK;
        end
    end
`else
    assign btb_hit = 1'b0;
    assign btb_tgt = '0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        redir_d = 1'b0;
        pred_d  = pred_q;
        cnt_d   = cnt_q;

        if (valid_q && bus.stall_en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end

        if (state_q == BOOT) begin
            // Redirects are ignored here; pc_q already holds RESET_PC.
            state_d = RUN;
            valid_d = 1'b1;
        end else if (bus.trap_en_i) begin
            pc_d    = bus.trap_addr_i & ALIGN_MASK;
            redir_d = 1'b1;
            pred_d  = 1'b0;
            state_d = RUN;
        end else if (bus.jump_en_i) begin
            pc_d    = bus.jump_addr_i & ALIGN_MASK;
            redir_d = 1'b1;
            pred_d  = 1'b0;
            state_d = RUN;
        end else begin
            state_d = bus.stall_en_i ? STALL : RUN;
            // Holding keeps pred_q: pc_o still is the predicted address.
            if (fire) begin
                if (btb_hit) begin
                    pc_d   = btb_tgt;
                    pred_d = 1'b1;
                end else begin
                    pc_d   = pc_q + INC_X;
                    pred_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            redir_q <= 1'b0;
            pred_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            redir_q <= redir_d;
            pred_q  <= pred_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.pc_valid_o   = valid_q;
    assign bus.redirect_o   = redir_q;
    assign bus.pred_taken_o = pred_q;
    assign bus.stall_cnt_o  = cnt_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table plus hand-written sequences for pc_gen.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(64)) bus();

    pc_gen #(
        .XLEN(64),
        .RESET_PC(64'h8000_0000),
        .INC(4),
        .BTB_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        stall;
        logic        ready;
        logic        trap;
        logic [63:0] taddr;
        logic        jump;
        logic [63:0] jaddr;
        logic [63:0] exp_pc;
        logic        exp_valid;
        logic        exp_redir;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] SRC_X = 64'h7000_0000;

    function automatic vec_t mk(input logic stall, input logic ready,
                                input logic trap, input logic [63:0] taddr,
                                input logic jump, input logic [63:0] jaddr,
                                input logic [63:0] exp_pc, input logic exp_valid,
                                input logic exp_redir, input logic [31:0] exp_cnt);
        vec_t v;
        v.stall = stall; v.ready = ready; v.trap = trap; v.taddr = taddr;
        v.jump = jump; v.jaddr = jaddr; v.exp_pc = exp_pc;
        v.exp_valid = exp_valid; v.exp_redir = exp_redir; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic stall, input logic ready,
                         input logic trap, input logic [63:0] taddr,
                         input logic jump, input logic [63:0] jaddr,
                         input logic [63:0] jsrc);
        @(negedge clk);
        rst                = r;
        bus.stall_en_i     = stall;
        bus.if_ready_i     = ready;
        bus.trap_en_i      = trap;
        bus.trap_addr_i    = taddr;
        bus.jump_en_i      = jump;
        bus.jump_addr_i    = jaddr;
        bus.jump_src_pc_i  = jsrc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [63:0] pc, input logic valid,
                             input logic redir, input logic pred, input logic [31:0] cnt);
        chk({tag, " pc"},    bus.pc_o, pc);
        chk({tag, " valid"}, 64'(bus.pc_valid_o), 64'(valid));
        chk({tag, " redir"}, 64'(bus.redirect_o), 64'(redir));
        chk({tag, " pred"},  64'(bus.pred_taken_o), 64'(pred));
        chk({tag, " cnt"},   64'(bus.stall_cnt_o), 64'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_pred_hit;
        bus.stall_en_i = 1'b0; bus.if_ready_i = 1'b0; bus.trap_en_i = 1'b0;
        bus.trap_addr_i = '0; bus.jump_en_i = 1'b0; bus.jump_addr_i = '0;
        bus.jump_src_pc_i = '0;

        //            stall ready trap taddr          jump jaddr                  exp_pc                 v  rd cnt
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0000,          1, 0, 0)); // boot -> run
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0004,          1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0008,          1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_000C,          1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0010,          1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0010,          1, 0, 1)); // stall x3
        vecs.push_back(mk(1, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0010,          1, 0, 2));
        vecs.push_back(mk(1, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0010,          1, 0, 3));
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0014,          1, 0, 3));
        vecs.push_back(mk(0, 1, 1, 64'h8000_1000, 1, 64'h8000_2000,          64'h8000_1000,          1, 1, 3)); // trap beats jump
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_1004,          1, 0, 3));
        vecs.push_back(mk(1, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_1004,          1, 0, 4));
        vecs.push_back(mk(1, 1, 0, 64'h0,          1, 64'h8000_0103,          64'h8000_0100,          1, 1, 5)); // jump in stall, aligned
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h8000_0104,          1, 0, 5));
        vecs.push_back(mk(0, 0, 0, 64'h0,          0, 64'h0,                  64'h8000_0104,          1, 0, 5)); // not ready
        vecs.push_back(mk(0, 0, 0, 64'h0,          1, 64'h8000_0201,          64'h8000_0200,          1, 1, 5)); // jump while not ready
        vecs.push_back(mk(0, 1, 0, 64'h0,          1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 5));
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h0,                  1, 0, 5)); // wrap
        vecs.push_back(mk(0, 0, 0, 64'h0,          0, 64'h0,                  64'h0,                  1, 0, 5));
        vecs.push_back(mk(0, 1, 0, 64'h0,          0, 64'h0,                  64'h4,                  1, 0, 5));

        // Reset held two cycles.
        drive(0, 0, 1, 0, '0, 0, '0, '0);
        drive(0, 0, 1, 0, '0, 0, '0, '0);
        check_out("reset", 64'h8000_0000, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(1, vecs[i].stall, vecs[i].ready, vecs[i].trap, vecs[i].taddr,
                  vecs[i].jump, vecs[i].jaddr, SRC_X);
            check_out($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                      vecs[i].exp_redir, 1'b0, vecs[i].exp_cnt);
        end

        // Reset mid-operation discards a concurrent redirect.
        drive(0, 0, 1, 0, '0, 1, 64'h8000_3000, SRC_X);
        check_out("midrst", 64'h8000_0000, 0, 0, 0, 0);
        // Redirect during BOOT is ignored.
        drive(1, 0, 1, 0, '0, 1, 64'h8000_3000, SRC_X);
        check_out("bootjmp", 64'h8000_0000, 1, 0, 0, 0);

        // Train src 80000020 -> 80000400, then walk up to 80000020.
        drive(1, 0, 1, 0, '0, 1, 64'h8000_0400, 64'h8000_0020);
        check_out("train", 64'h8000_0400, 1, 1, 0, 0);
        drive(1, 0, 1, 0, '0, 1, 64'h8000_0018, 64'h7000_0004);
        check_out("to18", 64'h8000_0018, 1, 1, 0, 0);
        drive(1, 0, 1, 0, '0, 0, '0, '0);
        check_out("seq1c", 64'h8000_001C, 1, 0, 0, 0);
        drive(1, 0, 1, 0, '0, 0, '0, '0);
        check_out("seq20", 64'h8000_0020, 1, 0, 0, 0);
`ifdef PC_GEN_BTB_EN
        exp_pred_hit = 1'b1;
        drive(1, 0, 1, 0, '0, 0, '0, '0);
        check_out("predict", 64'h8000_0400, 1, 0, 1, 0);
        drive(1, 1, 1, 0, '0, 0, '0, '0);
        chk("predhold pc", bus.pc_o, 64'h8000_0400);
        chk("predhold cnt", 64'(bus.stall_cnt_o), 64'd1);
        drive(1, 0, 1, 0, '0, 0, '0, '0);
        check_out("afterpred", 64'h8000_0404, 1, 0, 0, 1);
`else
        exp_pred_hit = 1'b0;
        drive(1, 0, 1, 0, '0, 0, '0, '0);
        check_out("nobtb", 64'h8000_0024, 1, 0, 0, 0);
        drive(1, 1, 1, 0, '0, 0, '0, '0);
        chk("hold pc", bus.pc_o, 64'h8000_0024);
        chk("hold cnt", 64'(bus.stall_cnt_o), 64'd1);
        drive(1, 0, 1, 0, '0, 0, '0, '0);
        check_out("resume", 64'h8000_0028, 1, 0, 0, 1);
`endif
        chk("pred final", 64'(bus.pred_taken_o), 64'(1'b0 & exp_pred_hit));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
